// File: rtl/avr_io_pkg.sv
// Shared definitions for the AVR I/O-mapped peripherals: register offsets and limits
// for the interrupt controller.
package avr_io_pkg;
    localparam logic [1:0] IRQ_PEND = 2'd0;
    localparam logic [1:0] IRQ_MASK = 2'd1;
    localparam logic [1:0] IRQ_MODE = 2'd2;
    localparam logic [1:0] IRQ_STAT = 2'd3;
    localparam int         MAX_IRQ  = 8;
endpackage

// File: rtl/avr_io_irqctl_line.sv
// Per-channel conditioning: optional 2-flop synchroniser, sampling and edge-history
// flops, and the pending latch for edge-mode channels.
module irq_line_cond #(
    parameter int SYNC = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    input  logic mode,
    input  logic clr,
    output logic active,
    output logic pend
);
    logic sync_out_s;
    logic samp_r;
    logic prev_r;
    logic pend_r;
    logic rise_s;

    generate
        if (SYNC != 0) begin : g_sync
            logic [1:0] sync_r;
            // Two-stage metastability filter for lines from other clock domains
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_r <= 2'b00;
                end else begin
                    sync_r <= {sync_r[0], irq};
                end
            end
            assign sync_out_s = sync_r[1];
        end else begin : g_nosync
            assign sync_out_s = irq;
        end
    endgenerate

    assign rise_s = samp_r & ~prev_r;

    // Sample the line, remember its previous value, and latch edge events (set beats clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_r <= 1'b0;
            prev_r <= 1'b0;
            pend_r <= 1'b0;
        end else begin
            samp_r <= sync_out_s;
            prev_r <= samp_r;
            // Leaving edge mode drops the latch; level channels never hold pending state
            pend_r <= mode & (rise_s | (pend_r & ~clr));
        end
    end

    // An edge detected this cycle already counts, so the request is not delayed by the latch
    assign active = mode ? (pend_r | rise_s) : samp_r;
    assign pend   = pend_r;
endmodule

// File: rtl/avr_io_irqctl.sv
// Interrupt controller for the AVR core: 4-register I/O peripheral, fixed-priority
// scan (bit 0 highest) and registered iflag/ivect toward the core.
module avr_io_irqctl
    import avr_io_pkg::*;
#(
    parameter int N_IRQ = 4,
    parameter int VEC_W = 2,
    parameter int SYNC  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             io_re,
    input  logic             io_we,
    input  logic [1:0]       io_a,
    output logic [7:0]       io_di,
    input  logic [7:0]       io_do,
    input  logic [N_IRQ-1:0] irq,
    input  logic             ack,
    input  logic [VEC_W-1:0] ack_vec,
    output logic             iflag,
    output logic [VEC_W-1:0] ivect
);
    logic [N_IRQ-1:0] mask_r;
    logic [N_IRQ-1:0] mode_r;
    logic [N_IRQ-1:0] clr_s;
    logic [N_IRQ-1:0] active_s;
    logic [N_IRQ-1:0] pend_s;
    logic [N_IRQ-1:0] req_s;
    logic [N_IRQ-1:0] pend_view_s;
    logic [VEC_W-1:0] ivect_s;
    logic [7:0]       rd_s;
    logic             wr_pend_s;
    logic             unused_s;

    assign wr_pend_s = io_we && (io_a == IRQ_PEND);
    assign unused_s  = &{1'b0, io_do};

    // Clear requests: W1C on PEND, or ack naming this channel (out-of-range vectors match nothing)
    always_comb begin
        clr_s = {N_IRQ{1'b0}};
        for (int i = 0; i < N_IRQ; i++) begin
            clr_s[i] = (wr_pend_s & io_do[i]) | (ack & (ack_vec == VEC_W'(i)));
        end
    end

    generate
        for (genvar g = 0; g < N_IRQ; g++) begin : g_line
            irq_line_cond #(.SYNC(SYNC)) u_line (
                .clk    (clk),
                .rst_n  (rst_n),
                .irq    (irq[g]),
                .mode   (mode_r[g]),
                .clr    (clr_s[g]),
                .active (active_s[g]),
                .pend   (pend_s[g])
            );
        end
    endgenerate

    assign req_s       = active_s & mask_r;
    assign pend_view_s = (mode_r & pend_s) | (~mode_r & active_s);

    // Priority scan: walk downward so the lowest requesting index is the last to win
    always_comb begin
        ivect_s = {VEC_W{1'b0}};
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req_s[i]) begin
                ivect_s = VEC_W'(i);
            end else begin
                ivect_s = ivect_s;
            end
        end
    end

    // Control registers and the registered request presented to the core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r <= {N_IRQ{1'b0}};
            mode_r <= {N_IRQ{1'b0}};
            iflag  <= 1'b0;
            ivect  <= {VEC_W{1'b0}};
        end else begin
            if (io_we && (io_a == IRQ_MASK)) begin
                mask_r <= io_do[N_IRQ-1:0];
            end
            if (io_we && (io_a == IRQ_MODE)) begin
                mode_r <= io_do[N_IRQ-1:0];
            end
            iflag <= |req_s;
            ivect <= ivect_s;
        end
    end

    // Read mux: combinational and zero when not selected, since io_di sits on a wired-OR bus
    always_comb begin
        rd_s = 8'h00;
        if (io_re) begin
            case (io_a)
                IRQ_PEND: rd_s = 8'(pend_view_s);
                IRQ_MASK: rd_s = 8'(mask_r);
                IRQ_MODE: rd_s = 8'(mode_r);
                IRQ_STAT: rd_s = {iflag, {(7 - VEC_W){1'b0}}, ivect};
                default:  rd_s = 8'h00;
            endcase
        end else begin
            rd_s = 8'h00;
        end
    end

    assign io_di = rd_s;
endmodule

// File: tb/tb_avr_io_irqctl.sv
// Scoreboard bench for avr_io_irqctl (N_IRQ=4, SYNC=0): directed scenarios then random
// traffic, checked against a rule-level reference model.
module tb_avr_io_irqctl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       io_re = 1'b0;
    logic       io_we = 1'b0;
    logic [1:0] io_a = 2'd0;
    logic [7:0] io_di;
    logic [7:0] io_do = 8'h00;
    logic [3:0] irq = 4'hF;
    logic       ack = 1'b0;
    logic [1:0] ack_vec = 2'd0;
    logic       iflag;
    logic [1:0] ivect;

    int n_chk = 0;
    int n_err = 0;

    logic [2:0] exp_q[$];
    logic [7:0] rd_q[$];

    // reference model state
    logic [3:0] m_mask = 4'h0, m_mode = 4'h0, m_pend = 4'h0;
    logic       m_iflag = 1'b0;
    logic [1:0] m_ivect = 2'd0;
    logic [3:0] samp_q[$];
    logic [3:0] cur, prv, rise, act, req, clr;

    avr_io_irqctl #(.N_IRQ(4), .VEC_W(2), .SYNC(0)) dut (
        .clk(clk), .rst_n(rst_n), .io_re(io_re), .io_we(io_we), .io_a(io_a),
        .io_di(io_di), .io_do(io_do), .irq(irq), .ack(ack), .ack_vec(ack_vec),
        .iflag(iflag), .ivect(ivect)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    function automatic logic [3:0] last_sample(input int back);
        if (samp_q.size() > back) return samp_q[samp_q.size() - 1 - back];
        return 4'h0;
    endfunction

    function automatic logic [7:0] model_read(input logic [1:0] a);
        logic [3:0] lvl;
        lvl = last_sample(0);
        case (a)
            2'd0:    return {4'h0, (m_mode & m_pend) | (~m_mode & lvl)};
            2'd1:    return {4'h0, m_mask};
            2'd2:    return {4'h0, m_mode};
            default: return {m_iflag, 5'b00000, m_ivect};
        endcase
    endfunction

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, got, exp, $time);
        end
    endtask

    // one bus cycle; a read's expected data is queued from the model's pre-edge view
    task automatic drive(input logic [3:0] i_irq, input logic re, input logic we,
                         input logic [1:0] a, input logic [7:0] d,
                         input logic ak, input logic [1:0] av);
        @(negedge clk);
        irq = i_irq; io_re = re; io_we = we; io_a = a; io_do = d; ack = ak; ack_vec = av;
        if (re) rd_q.push_back(model_read(a));
    endtask

    task automatic idle(input logic [3:0] i_irq, input int n);
        for (int k = 0; k < n; k++) drive(i_irq, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        drive(4'h0, 1'b0, 1'b1, a, d, 1'b0, 2'd0);
    endtask

    task automatic rd(input logic [1:0] a);
        drive(4'h0, 1'b1, 1'b0, a, 8'h00, 1'b0, 2'd0);
    endtask

    // Reference model: each edge samples irq; an edge channel latches a 0->1 of the sample
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mask = 4'h0; m_mode = 4'h0; m_pend = 4'h0;
                m_iflag = 1'b0; m_ivect = 2'd0;
                samp_q.delete();
                exp_q.delete();
            end else begin
                cur  = last_sample(0);
                prv  = last_sample(1);
                rise = cur & ~prv;
                act  = (m_mode & (m_pend | rise)) | (~m_mode & cur);
                req  = act & m_mask;
                m_iflag = |req;
                m_ivect = lowest(req);
                exp_q.push_back({m_iflag, m_ivect});
                clr = (io_we && io_a == 2'd0) ? io_do[3:0] : 4'h0;
                if (ack) clr[ack_vec] = 1'b1;
                m_pend = m_mode & (rise | (m_pend & ~clr));
                if (io_we && io_a == 2'd1) m_mask = io_do[3:0];
                if (io_we && io_a == 2'd2) m_mode = io_do[3:0];
                samp_q.push_back(irq);
                if (samp_q.size() > 2) void'(samp_q.pop_front());
            end
        end
    end

    // Output monitor: registered request after every edge
    initial begin
        logic [2:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("iflag", {7'd0, iflag}, {7'd0, e[2]});
                check("ivect", {6'd0, ivect}, {6'd0, e[1:0]});
            end
        end
    end

    // Read monitor: io_di sampled mid-cycle while io_re is held
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                check("io_di", io_di, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] r_irq;
        int r;
        // reset held with all lines high
        repeat (3) @(negedge clk);
        check("rst_iflag", {7'd0, iflag}, 8'h00);
        check("rst_ivect", {6'd0, ivect}, 8'h00);
        io_re = 1'b1;
        for (int a = 0; a < 4; a++) begin
            io_a = 2'(a);
            #1;
            check("rst_reg", io_di, 8'h00);
        end
        io_re = 1'b0; io_a = 2'd1;
        #1;
        check("rst_idle_bus", io_di, 8'h00);
        irq = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;

        // level priority
        wr(2'd1, 8'h0F);
        wr(2'd2, 8'h00);
        idle(4'b1010, 3);
        drive(4'b1010, 1'b1, 1'b0, 2'd3, 8'h00, 1'b0, 2'd0);
        idle(4'b1000, 3);
        drive(4'b1000, 1'b1, 1'b0, 2'd3, 8'h00, 1'b0, 2'd0);
        idle(4'b0000, 3);

        // edge latch and ack
        wr(2'd2, 8'h04);
        wr(2'd1, 8'h04);
        idle(4'b0100, 1);
        idle(4'b0000, 2);
        rd(2'd0);
        rd(2'd3);
        drive(4'h0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
        idle(4'h0, 1);
        rd(2'd0);
        rd(2'd3);

        // set wins over a simultaneous W1C
        idle(4'b0100, 1);
        drive(4'b0000, 1'b0, 1'b1, 2'd0, 8'h04, 1'b0, 2'd0);
        rd(2'd0);
        idle(4'h0, 2);

        // masked latch then unmask
        wr(2'd2, 8'h01);
        wr(2'd1, 8'h00);
        idle(4'b0001, 1);
        idle(4'b0000, 2);
        rd(2'd0);
        rd(2'd3);
        wr(2'd1, 8'h01);
        idle(4'h0, 2);
        rd(2'd3);

        // async reset with pending state
        wr(2'd2, 8'h05);
        wr(2'd1, 8'h05);
        idle(4'b0101, 1);
        idle(4'b0000, 2);
        rd(2'd0);
        @(negedge clk);
        #3;
        io_re = 1'b1; io_we = 1'b0; io_a = 2'd0;
        rst_n = 1'b0;
        #1;
        check("async_iflag", {7'd0, iflag}, 8'h00);
        check("async_pend", io_di, 8'h00);
        repeat (2) @(negedge clk);
        io_re = 1'b0;
        rst_n = 1'b1;

        // random traffic
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 9);
            r_irq = 4'($urandom_range(0, 15));
            drive(r_irq, 1'($urandom_range(0, 1)), (r < 3), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)), (r == 9), 2'($urandom_range(0, 3)));
        end
        idle(4'h0, 3);
        @(posedge clk);
        #3;
        check("queues_drained", 8'(exp_q.size() + rd_q.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/avr_io_irqctl.md
# avr_io_irqctl

Parametrised interrupt controller for the AVR SoC, replacing the fixed 4-line combinational priority encoder between peripherals and the core. Handles up to 8 request lines, each with an enable mask bit and a level/edge mode bit. Edge events latch into a pending register. The block presents a registered `iflag`/`ivect` pair to the core and clears latched edge events on the core's acknowledge. Lives on the I/O-mapped bus as a 4-register peripheral, wired like the UART and timer.

## Interface
- `N_IRQ`, 4: number of request lines, 1..8.
- `VEC_W`, 2: width of `ivect`/`ack_vec`. Must satisfy 2^VEC_W ≥ N_IRQ. Matches the core `intr_width`.
- `SYNC`, 0: 1 inserts a 2-flop synchroniser per line for asynchronous sources. 0 means the lines are already on `clk`.

Ports:
- `clk`, in, 1: system clock (`system_clk`).
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `io_re`, in, 1: I/O read strobe, already qualified by the top-level address decode.
- `io_we`, in, 1: I/O write strobe, already qualified.
- `io_a`, in, 2: register select.
- `io_di`, out, 8: read data to the core. Drives 0 whenever `io_re`=0, because it shares a `wor` bus.
- `io_do`, in, 8: write data from the core.
- `irq`, in, N_IRQ: request lines. Bit 0 has the highest priority.
- `ack`, in, 1: one-cycle strobe when the core vectors to an interrupt.
- `ack_vec`, in, VEC_W: vector being acknowledged.
- `iflag`, out, 1: interrupt request to the core. Registered.
- `ivect`, out, VEC_W: index of the highest-priority active channel. Registered.

## Operation
- **Register map** (bits ≥ N_IRQ read 0 and ignore writes):
  - 0 PEND: read returns the raw active vector. Write-1-to-clear affects edge-mode bits only.
  - 1 MASK: R/W. 1 enables the channel.
  - 2 MODE: R/W. 1 selects edge mode, 0 selects level mode.
  - 3 STAT: read-only, `{iflag, 7-VEC_W zeros, ivect}`. Writes are ignored.
- **Level channel:** active = the sampled `irq[i]`, no latching. The source holds the line until it is serviced. `ack` has no effect on the channel.
- **Edge channel:** a rising edge of the sampled line (previous 0, current 1) sets `pend[i]`. `pend[i]` clears on a PEND write with bit i=1, or on `ack` with `ack_vec`==i.
- `active[i]` = MODE[i] ? `pend[i]` : `irq_s[i]`.
- `req[i]` = `active[i]` & MASK[i].
- `iflag` <= |req.
- `ivect` <= the lowest i with `req[i]`=1, else 0.
- **Set vs clear in the same cycle:** when an edge event and a clear (W1C or ack) hit the same bit, the set wins. No event is lost.
- **MODE change:** changing MODE[i] clears `pend[i]`.
- **Edges while masked:** edges still latch into `pend[i]` when MASK[i]=0. Unmasking later raises `iflag`.
- **Reset:** `pend`, MASK, MODE, the edge-history flops, the synchronisers, `iflag`, `ivect`, and `io_di` all go to 0. Reset mid-event discards the pending state.

## Timing
- **SYNC=0:** `irq` rises before clk edge k. `pend`/`irq_s` update at edge k+1. `iflag`/`ivect` are valid after edge k+1 when computed from the next-state value; the requirement is `iflag` high in the cycle following edge k+1 (latency 2 edges from the first sampling edge).
- **SYNC=1:** add 2 cycles.
- **Register writes:** take effect at the write edge. `iflag` reflects a MASK/MODE/PEND write one edge later.
- **Reads:** combinational within the `io_re` cycle, showing pre-edge register values.
- **ack:** the clear applies at the edge where `ack`=1. `iflag` drops at the following edge if nothing else is requesting. An `ack` with an out-of-range `ack_vec` is ignored.

## Structure
- **Shared package `avr_io_pkg`:**
  - register offsets `IRQ_PEND`=0, `IRQ_MASK`=1, `IRQ_MODE`=2, `IRQ_STAT`=3.
  - a `MAX_IRQ`=8 constant.
- **Sub-module `irq_line_cond`:** one instance per channel. Contains the optional 2-flop sync, the edge-history flop, and the `pend` set/clear logic. Inputs: `clk`, `rst_n`, `irq`, `mode`, `clr`. Outputs: `active`, `pend`.
- **Top of this block:** the register file, the priority scan written as a for-loop, and the output registers.

## Test plan
All cases use N_IRQ=4, SYNC=0.
- **Reset:** `rst_n`=0 while `clk` is running and `irq`=4'hF → `iflag`=0, `ivect`=0, all registers read 0, `io_di`=0 when `io_re`=0.
- **Level priority:** MASK=0x0F, MODE=0, `irq`=4'b1010 → `iflag`=1, `ivect`=1 within 2 edges. Drop `irq[1]` → `ivect`=3. `irq`=0 → `iflag`=0.
- **Edge latch + ack:** MODE=0x04, MASK=0x04, single-cycle pulse on `irq[2]` → PEND reads 0x04, `iflag`=1, `ivect`=2. `ack`=1 with `ack_vec`=2 → PEND=0 and `iflag`=0 one edge later.
- **Set-wins collision:** new rising edge on `irq[2]` in the same cycle as a W1C of 0x04 → PEND stays 0x04.
- **Masked latch:** MODE=0x01, MASK=0, pulse on `irq[0]` → `iflag`=0, PEND=0x01. Write MASK=0x01 → `iflag`=1 one edge later. Read STAT → 0x80.
- **Async reset mid-pending:** with PEND=0x05, assert `rst_n`=0 between clock edges → `iflag` and PEND clear immediately, with no clock required.
